mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Registered write-back stage between the data Memory / ALU outputs and the Registers write ports.
//  Selects write-back data (byte/word load, ALU low, register move), buffers one extra entry as a skid slot, and forwards the pending write.
//  Sequences HALT: drains in-flight writes, then freezes the stage.
// PARAMETERS
//  DW     16  datapath width (word, ALU low/high, register data)
//  AW      4  register address width
// PORTS
//  CLOCK      in   1   rising-edge clock
//  CLEAR      in   1   asynchronous, active-high reset
//  in_valid   in   1   MEM-stage result valid this cycle
//  in_ready   out  1   stage can accept; transfer when in_valid&&in_ready
//  in_halt    in   1   accompanying instruction is HALT (no write)
//  in_wdst    in   2   write dest: 00 none, 01 R[waddr], 10 R15, 11 both
//  in_waddr   in   AW  destination register for write port 1
//  in_mbyte   in   1   1: load data is zero-extended byte, 0: word
//  in_down    in   1   1: write port 1 takes load data, 0: ALU low
//  in_mv1     in   1   1: write port 1 takes down-mux, 0: in_rdata2 (move)
//  in_word    in   DW  Memory word read data
//  in_byte    in   8   Memory byte read data
//  in_low     in   DW  ALU low result
//  in_high    in   DW  ALU high result (R15 write data)
//  in_rdata2  in   DW  register read data 2
//  wb_stall   in   1   register file cannot take a write this cycle
//  wb_valid   out  1   wb_* outputs carry a write this cycle
//  wb_wdst    out  2   write dest code; forced 00 when wb_valid=0
//  wb_waddr   out  AW  write port 1 address
//  wb_w1      out  DW  write port 1 data
//  wb_w15     out  DW  R15 data
//  fwd_valid  out  1   head entry writes R[waddr] (wdst[0]=1)
//  fwd_addr   out  AW  = wb_waddr
//  fwd_data   out  DW  = wb_w1
//  halted     out  1   stage frozen after HALT drained
// BEHAVIOUR
//  Reset (async, CLEAR=1): both slots empty, FSM=RUN; all outputs 0 except in_ready=0 while CLEAR=1, 1 first cycle after.
//  Data select at input (combinational before capture):
//   mm = in_mbyte ? {8'h00,in_byte} : in_word; dw = in_down ? mm : in_low; w1 = in_mv1 ? dw : in_rdata2.
//  Storage: head slot (drives wb_*) + skid slot. Latency: accepted entry appears on wb_* next cycle.
//  Head retires on a cycle with wb_valid && !wb_stall; skid then moves to head same edge.
//  in_ready = !skid_full && state==RUN (registered-free; combinational from state/occupancy).
//  Simultaneous accept+retire with skid empty: new entry goes directly to head, no bubble.
//  Accept with head full and not retiring: entry goes to skid; in_ready drops next cycle.
//  wb_stall with both slots full: hold all wb_* stable; no entry lost, none duplicated.
//  HALT entry: stored as wdst=00 (never writes), never asserts wb_valid; occupies no slot.
//  FSM: RUN -accept with in_halt-> DRAIN; DRAIN -both slots empty-> HALTED; HALTED held until CLEAR.
//   DRAIN: in_ready=0, remaining writes retire normally. HALTED: in_ready=0, halted=1, wb_valid=0.
//  HALT accepted with empty slots: DRAIN lasts 1 cycle, halted=1 on the 2nd edge after accept.
//  CLEAR mid-operation: pending entries discarded, no write emitted after CLEAR asserts.
//  wb_wdst code 00 with in_valid=1 (e.g. store): entry passes through with wb_valid=1, wb_wdst=00, no fwd_valid.
// TESTING
//  T1 load byte: in_mbyte=1,in_down=1,in_mv1=1,in_byte=8'hA5,wdst=01,waddr=3 -> next cycle wb_w1=16'h00A5, wb_waddr=3, fwd_valid=1.
//  T2 ALU+R15: in_down=0,in_mv1=1,in_low=16'h1234,in_high=16'h0001,wdst=11 -> wb_w1=16'h1234, wb_w15=16'h0001, wb_wdst=11.
//  T3 stall: wb_stall=1 for 3 cycles while 3 valid inputs offered -> 2 accepted, in_ready=0, wb_* held; release -> 2 writes in order, no loss.
//  T4 halt: write to R5 in head, stall 1 cycle, then HALT accepted -> R5 write retires, halted=1, in_ready stays 0 for 10 cycles.
//  T5 reset mid-stall: both slots full, CLEAR=1 between edges -> wb_valid=0 immediately, halted=0, in_ready=1 after release.
//  T6 move: in_mv1=0,in_rdata2=16'hBEEF,wdst=01 -> wb_w1=16'hBEEF regardless of in_word/in_low.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Handshake and data bundle between the MEM stage, the write-back stage and the register file.
interface mem_wb_stage_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          in_halt;
  logic [1:0]    in_wdst;
  logic [AW-1:0] in_waddr;
  logic          in_mbyte;
  logic          in_down;
  logic          in_mv1;
  logic [DW-1:0] in_word;
  logic [7:0]    in_byte;
  logic [DW-1:0] in_low;
  logic [DW-1:0] in_high;
  logic [DW-1:0] in_rdata2;
  logic          wb_stall;
  logic          wb_valid;
  logic [1:0]    wb_wdst;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_w1;
  logic [DW-1:0] wb_w15;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic          halted;

  // Upstream/register-file side: drives the MEM results and the stall.
  modport master (
    output in_valid, in_halt, in_wdst, in_waddr, in_mbyte, in_down, in_mv1,
           in_word, in_byte, in_low, in_high, in_rdata2, wb_stall,
    input  in_ready, wb_valid, wb_wdst, wb_waddr, wb_w1, wb_w15,
           fwd_valid, fwd_addr, fwd_data, halted
  );

  // The write-back stage itself.
  modport slave (
    input  in_valid, in_halt, in_wdst, in_waddr, in_mbyte, in_down, in_mv1,
           in_word, in_byte, in_low, in_high, in_rdata2, wb_stall,
    output in_ready, wb_valid, wb_wdst, wb_waddr, wb_w1, wb_w15,
           fwd_valid, fwd_addr, fwd_data, halted
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Registered write-back stage: selects write data, holds a head entry plus one
// skid entry so upstream can keep streaming under register-file stalls, and
// sequences HALT (drain pending writes, then freeze until CLEAR).
module mem_wb_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input logic           CLOCK,
  input logic           CLEAR,
  mem_wb_stage_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]    wdst;
    logic [AW-1:0] waddr;
    logic [DW-1:0] w1;
    logic [DW-1:0] w15;
  } entry_t;

  // Write port 1 data: byte/word load, ALU low, or register move.
  function automatic logic [DW-1:0] sel_w1(
    input logic          mbyte,
    input logic          down,
    input logic          mv1,
    input logic [DW-1:0] word,
    input logic [7:0]    byte_d,
    input logic [DW-1:0] low,
    input logic [DW-1:0] rdata2
  );
    logic [DW-1:0] mm;
    logic [DW-1:0] dw;
    mm = mbyte ? {{(DW-8){1'b0}}, byte_d} : word;
    dw = down ? mm : low;
    return mv1 ? dw : rdata2;
  endfunction

  state_t state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, in_entry;
  logic   head_full_q, head_full_d, skid_full_q, skid_full_d;
  logic   in_ready, wb_valid, halted, push, halt_acc, pop;

  assign in_entry = '{wdst:  bus.in_wdst,
                      waddr: bus.in_waddr,
                      w1:    sel_w1(bus.in_mbyte, bus.in_down, bus.in_mv1, bus.in_word,
                                    bus.in_byte, bus.in_low, bus.in_rdata2),
                      w15:   bus.in_high};

  assign push     = bus.in_valid && in_ready && !bus.in_halt;
  assign halt_acc = bus.in_valid && in_ready && bus.in_halt;
  assign pop      = wb_valid && !bus.wb_stall;

  // FSM state register.
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: a HALT acceptance starts draining; an empty stage while draining freezes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_acc) state_d = DRAIN;
      DRAIN:   if (!head_full_q && !skid_full_q) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: CLEAR holds in_ready low; only RUN accepts; HALTED never writes.
  always_comb begin
    in_ready = !CLEAR && !skid_full_q && (state_q == RUN);
    halted   = (state_q == HALTED);
    wb_valid = head_full_q && (state_q != HALTED);
  end

  // Slot bookkeeping: skid refills head on retire; a new entry bypasses the skid when possible.
  always_comb begin
    head_d      = head_q;
    skid_d      = skid_q;
    head_full_d = head_full_q;
    skid_full_d = skid_full_q;
    if (pop) begin
      if (skid_full_q) begin
        head_d      = skid_q;
        skid_full_d = 1'b0;
      end else if (push) begin
        head_d = in_entry;
      end else begin
        head_full_d = 1'b0;
      end
    end else if (push) begin
      if (!head_full_q) begin
        head_d      = in_entry;
        head_full_d = 1'b1;
      end else begin
        skid_d      = in_entry;
        skid_full_d = 1'b1;
      end
    end
  end

  // Slot registers; data is cleared too so every output reads 0 out of reset.
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      head_q      <= '0;
      skid_q      <= '0;
      head_full_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      head_full_q <= head_full_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.halted    = halted;
  assign bus.wb_valid  = wb_valid;
  assign bus.wb_wdst   = wb_valid ? head_q.wdst : 2'b00;
  assign bus.wb_waddr  = head_q.waddr;
  assign bus.wb_w1     = head_q.w1;
  assign bus.wb_w15    = head_q.w15;
  assign bus.fwd_valid = wb_valid && head_q.wdst[0];
  assign bus.fwd_addr  = head_q.waddr;
  assign bus.fwd_data  = head_q.w1;

endmodule
